// File: rtl/tron_pkg.sv
// Shared encodings for the Tron round controller.
//   state_e   : controller state as seen on the state output
//   DIR_*     : head direction encoding used by p1_dir/p2_dir
//   opposite(): direction reached by a 180-degree turn
package tron_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Up/down and right/left differ only in the top bit.
    function automatic logic [1:0] opposite(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/tron_dir_reg.sv
// Per-player direction register.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset (direction -> StartDir)
//   load_i   : reload StartDir and drop any pending request
//   strobe_i : commit the latest pending request (game step)
//   btn_i    : {U,R,D,L} raw button request
//   dir_o    : committed direction
module tron_dir_reg
    import tron_pkg::*;
#(
    parameter logic [1:0] StartDir = DIR_RIGHT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       strobe_i,
    input  logic [3:0] btn_i,
    output logic [1:0] dir_o
);

    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic       pend_valid_q, pend_valid_d;

    logic       btn_onehot;
    logic [1:0] req_dir;
    logic       req_valid;

    assign btn_onehot = (btn_i != 4'b0000) && ((btn_i & (btn_i - 4'd1)) == 4'b0000);

    always_comb begin
        req_dir = DIR_LEFT;
        if (btn_i[3]) begin
            req_dir = DIR_UP;
        end else if (btn_i[2]) begin
            req_dir = DIR_RIGHT;
        end else if (btn_i[1]) begin
            req_dir = DIR_DOWN;
        end
    end

    // Reversal is judged against the committed direction; pending is cleared
    // whenever that direction changes, so a stale pending can never reverse.
    assign req_valid = btn_onehot && (req_dir != opposite(dir_q));

    always_comb begin
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;

        if (req_valid) begin
            pend_dir_d   = req_dir;
            pend_valid_d = 1'b1;
        end

        if (load_i) begin
            dir_d        = StartDir;
            pend_dir_d   = StartDir;
            pend_valid_d = 1'b0;
        end else if (strobe_i) begin
            if (pend_valid_d) begin
                dir_d = pend_dir_d;
            end
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q        <= StartDir;
            pend_dir_q   <= StartDir;
            pend_valid_q <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign dir_o = dir_q;

endmodule

// File: rtl/tron_game_ctrl.sv
// Round sequencer and scorekeeper for two-player Tron.
//   clk, reset            : system clock, asynchronous active-high reset
//   start                 : match-enable level
//   tick                  : one-cycle game-step strobe
//   p1_btn, p2_btn        : {U,R,D,L} direction requests
//   p1_crash, p2_crash    : head collision flags from the datapath
//   state                 : 00 idle, 01 play, 10 round-over pause, 11 match done
//   move_en               : one-cycle head-advance pulse
//   clear_arena           : arena reinitialise request
//   p1_dir, p2_dir        : committed directions
//   p1_score, p2_score    : rounds won
//   p1_win, p2_win        : match winner flags
module tron_game_ctrl
    import tron_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 10,
    parameter int unsigned PAUSE_TICKS  = 32,
    parameter logic [1:0]  P1_START_DIR = 2'b01,
    parameter logic [1:0]  P2_START_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] p1_btn,
    input  logic [3:0] p2_btn,
    input  logic       p1_crash,
    input  logic       p2_crash,
    output logic [1:0] state,
    output logic       move_en,
    output logic       clear_arena,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       p1_win,
    output logic       p2_win
);

    localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
    localparam logic [7:0] PauseLast = 8'(PAUSE_TICKS - 1);

    state_e     state_q, state_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic [7:0] pause_q, pause_d;
    logic       move_en_q, move_en_d;
    logic       clear_q, clear_d;
    logic       p1_win_q, p1_win_d;
    logic       p2_win_q, p2_win_d;
    logic       restart;
    logic       dir_load;

    always_comb begin
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        pause_d    = pause_q;
        move_en_d  = 1'b0;
        restart    = 1'b0;

        unique case (state_q)
            QI: begin
                p1_score_d = '0;
                p2_score_d = '0;
                pause_d    = '0;
                if (start) begin
                    state_d = QGAME_1;
                end
            end
            QGAME_1: begin
                if (!start) begin
                    state_d    = QI;
                    p1_score_d = '0;
                    p2_score_d = '0;
                end else if (p1_crash || p2_crash) begin
                    // Crash wins over a same-cycle tick; a double crash is a draw.
                    state_d = QGAME_2;
                    pause_d = '0;
                    if (p1_crash && !p2_crash && (p2_score_q != WinScore)) begin
                        p2_score_d = p2_score_q + 4'd1;
                    end
                    if (p2_crash && !p1_crash && (p1_score_q != WinScore)) begin
                        p1_score_d = p1_score_q + 4'd1;
                    end
                end else if (tick) begin
                    move_en_d = 1'b1;
                end
            end
            QGAME_2: begin
                if (!start) begin
                    state_d    = QI;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    pause_d    = '0;
                end else if (tick) begin
                    if (pause_q == PauseLast) begin
                        pause_d = '0;
                        if ((p1_score_q == WinScore) || (p2_score_q == WinScore)) begin
                            state_d = QDONE;
                        end else begin
                            state_d = QGAME_1;
                            restart = 1'b1;
                        end
                    end else begin
                        pause_d = pause_q + 8'd1;
                    end
                end
            end
            QDONE: begin
                if (!start) begin
                    state_d    = QI;
                    p1_score_d = '0;
                    p2_score_d = '0;
                end
            end
            default: state_d = QI;
        endcase
    end

    assign clear_d  = (state_d == QI) || restart;
    // Keep directions pinned to their start values for the whole idle period.
    assign dir_load = (state_q == QI) || clear_d;
    assign p1_win_d = (state_d == QDONE) && (p1_score_d == WinScore);
    assign p2_win_d = (state_d == QDONE) && (p2_score_d == WinScore);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= QI;
            p1_score_q <= '0;
            p2_score_q <= '0;
            pause_q    <= '0;
            move_en_q  <= 1'b0;
            clear_q    <= 1'b1;
            p1_win_q   <= 1'b0;
            p2_win_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            pause_q    <= pause_d;
            move_en_q  <= move_en_d;
            clear_q    <= clear_d;
            p1_win_q   <= p1_win_d;
            p2_win_q   <= p2_win_d;
        end
    end

    // Directions commit on the same edge that raises move_en.
    tron_dir_reg #(
        .StartDir(P1_START_DIR)
    ) u_p1_dir (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (dir_load),
        .strobe_i(move_en_d),
        .btn_i   (p1_btn),
        .dir_o   (p1_dir)
    );

    tron_dir_reg #(
        .StartDir(P2_START_DIR)
    ) u_p2_dir (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (dir_load),
        .strobe_i(move_en_d),
        .btn_i   (p2_btn),
        .dir_o   (p2_dir)
    );

    assign state       = state_q;
    assign move_en     = move_en_q;
    assign clear_arena = clear_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;
    assign p1_win      = p1_win_q;
    assign p2_win      = p2_win_q;

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Randomised bench for tron_game_ctrl against a behavioural match model.
module tb_tron_game_ctrl;

    localparam int WIN   = 10;
    localparam int PAUSE = 32;
    localparam int P1_START = 1;
    localparam int P2_START = 3;

    logic       clk = 1'b0;
    logic       reset, start, tick, p1_crash, p2_crash;
    logic [3:0] p1_btn, p2_btn;
    logic [1:0] state, p1_dir, p2_dir;
    logic       move_en, clear_arena, p1_win, p2_win;
    logic [3:0] p1_score, p2_score;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 playing, 2 between rounds, 3 match over.
    int m_mode, m_s1, m_s2, m_pause_ticks;
    int m_move, m_clear, m_w1, m_w2;
    int m_dir[2];
    int m_pend[2];   // -1 = nothing pending

    tron_game_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick       (tick),
        .p1_btn     (p1_btn),
        .p2_btn     (p2_btn),
        .p1_crash   (p1_crash),
        .p2_crash   (p2_crash),
        .state      (state),
        .move_en    (move_en),
        .clear_arena(clear_arena),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .p1_win     (p1_win),
        .p2_win     (p2_win)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int btn_dir(input logic [3:0] b);
        if ($countones(b) != 1) return -1;
        if (b[3]) return 0;
        if (b[2]) return 1;
        if (b[1]) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_s1 = 0; m_s2 = 0; m_pause_ticks = 0;
        m_move = 0; m_clear = 1; m_w1 = 0; m_w2 = 0;
        m_dir[0] = P1_START; m_dir[1] = P2_START;
        m_pend[0] = -1; m_pend[1] = -1;
    endtask

    task automatic model_step();
        int old_mode = m_mode;
        int restart  = 0;
        int req;
        logic [3:0] b;
        m_move = 0;
        // Latest legal request becomes pending; reversal judged on the current heading.
        for (int p = 0; p < 2; p++) begin
            b   = (p == 0) ? p1_btn : p2_btn;
            req = btn_dir(b);
            if (req >= 0 && req != (m_dir[p] + 2) % 4) m_pend[p] = req;
        end
        if (old_mode != 0 && !start) begin
            m_mode = 0;
        end else if (old_mode == 0) begin
            if (start) m_mode = 1;
        end else if (old_mode == 1) begin
            if (p1_crash || p2_crash) begin
                m_mode = 2;
                m_pause_ticks = 0;
                if (p1_crash && !p2_crash && m_s2 < WIN) m_s2++;
                if (p2_crash && !p1_crash && m_s1 < WIN) m_s1++;
            end else if (tick) begin
                m_move = 1;
            end
        end else if (old_mode == 2) begin
            if (tick) begin
                m_pause_ticks++;
                if (m_pause_ticks == PAUSE) begin
                    if (m_s1 == WIN || m_s2 == WIN) m_mode = 3;
                    else begin
                        m_mode  = 1;
                        restart = 1;
                    end
                end
            end
        end
        if (m_mode == 0) begin
            m_s1 = 0; m_s2 = 0;
        end
        if (m_move) begin
            for (int p = 0; p < 2; p++) begin
                if (m_pend[p] >= 0) m_dir[p] = m_pend[p];
                m_pend[p] = -1;
            end
        end
        m_clear = (m_mode == 0 || restart) ? 1 : 0;
        if (old_mode == 0 || m_clear) begin
            m_dir[0] = P1_START; m_dir[1] = P2_START;
            m_pend[0] = -1; m_pend[1] = -1;
        end
        m_w1 = (m_mode == 3 && m_s1 == WIN) ? 1 : 0;
        m_w2 = (m_mode == 3 && m_s2 == WIN) ? 1 : 0;
    endtask

    task automatic check_all();
        check_eq("state", int'(state), m_mode);
        check_eq("move_en", int'(move_en), m_move);
        check_eq("clear_arena", int'(clear_arena), m_clear);
        check_eq("p1_dir", int'(p1_dir), m_dir[0]);
        check_eq("p2_dir", int'(p2_dir), m_dir[1]);
        check_eq("p1_score", int'(p1_score), m_s1);
        check_eq("p2_score", int'(p2_score), m_s2);
        check_eq("p1_win", int'(p1_win), m_w1);
        check_eq("p2_win", int'(p2_win), m_w2);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    function automatic logic [3:0] rand_btn();
        int r = $urandom_range(0, 9);
        if (r < 5) return 4'b0000;
        if (r < 8) return 4'b0001 << $urandom_range(0, 3);
        return 4'($urandom);
    endfunction

    task automatic rand_inputs(input int crash_div);
        tick   = ($urandom_range(0, 3) == 0);
        p1_btn = rand_btn();
        p2_btn = rand_btn();
        p1_crash = 1'b0;
        p2_crash = 1'b0;
        if ($urandom_range(0, crash_div - 1) == 0) begin
            case ($urandom_range(0, 2))
                0: p1_crash = 1'b1;
                1: p2_crash = 1'b1;
                default: begin p1_crash = 1'b1; p2_crash = 1'b1; end
            endcase
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0;
        p1_btn = '0; p2_btn = '0; p1_crash = 1'b0; p2_crash = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;

        // Idle with start low: random traffic must not disturb anything.
        for (int i = 0; i < 100; i++) begin
            rand_inputs(8);
            cycle();
        end

        // Random play with occasional aborts.
        start = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rand_inputs(40);
            start = ($urandom_range(0, 599) != 0);
            cycle();
        end

        // Fresh match where P2 keeps crashing so P1 takes it.
        start = 1'b0;
        rand_inputs(1000);
        cycle();
        start = 1'b1;
        for (int i = 0; i < 3000 && m_mode != 3; i++) begin
            rand_inputs(1000000);
            tick = 1'b1;
            p1_crash = 1'b0;
            p2_crash = (i % 4 == 3);
            cycle();
        end
        check_eq("done_reached", int'(state), 3);
        check_eq("done_p1_win", int'(p1_win), 1);
        check_eq("done_p2_win", int'(p2_win), 0);
        for (int i = 0; i < 5; i++) begin
            rand_inputs(3);
            cycle();
        end
        start = 1'b0;
        cycle();
        check_eq("abort_p1_score", int'(p1_score), 0);

        // Enter a pause, then hit reset asynchronously mid-cycle.
        start = 1'b1;
        for (int i = 0; i < 200 && m_mode != 2; i++) begin
            rand_inputs(1000000);
            p1_crash = (i > 3);
            cycle();
        end
        check_eq("pause_reached", int'(state), 2);
        p1_crash = 1'b0;
        tick = 1'b0;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_inputs(30);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
